// File: rtl/vd_host.sv
// vd_host: host-side initiator for the vector divider.
// It loads (X, Y) operand pairs into the shared RAM, programs the pair count,
// starts the divider, waits out its busy cycle and streams the quotients back.
module vd_host #(
    parameter int RAM_SIZE  = 10,
    parameter int NBITS     = 32,
    parameter int RES_BASE  = 512,
    parameter int MAX_PAIRS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    // operand stream
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [NBITS-1:0]    i_in_data,
    input  logic                i_in_last,
    // result stream
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [NBITS-1:0]    o_out_data,
    output logic                o_out_last,
    // host side of the RAM mux
    output logic [RAM_SIZE-1:0] o_addr,
    output logic [NBITS-1:0]    o_wdata,
    output logic                o_wenable,
    input  logic [NBITS-1:0]    i_rdata,
    // divider control
    output logic [RAM_SIZE-1:0] o_ndata,
    output logic                o_startvd,
    input  logic                i_busyvd,
    output logic                o_ram_owner_vd,
    output logic                o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RD_ADDR,
        S_RD_DATA,
        S_OUT
    } state_t;

    localparam logic [RAM_SIZE-1:0] L_RES_BASE = RAM_SIZE'(RES_BASE);
    localparam logic [RAM_SIZE-1:0] L_MAX      = RAM_SIZE'(MAX_PAIRS);
    localparam logic [RAM_SIZE-1:0] L_ONE      = RAM_SIZE'(1);

    state_t              r_state;
    logic                r_in_ready;
    logic [RAM_SIZE-1:0] r_p;
    logic                r_phase;     // 0 = X word, 1 = Y word
    logic [RAM_SIZE-1:0] r_r;
    logic [RAM_SIZE-1:0] r_addr;      // read address, only nonzero in RD_ADDR
    logic [RAM_SIZE-1:0] r_ndata;
    logic                r_startvd;
    logic                r_owner;
    logic                r_err;
    logic                r_out_valid;
    logic                r_out_last;
    logic [NBITS-1:0]    r_out_data;

    logic                w_accept;
    logic                w_first;
    logic [RAM_SIZE-1:0] w_p;
    logic                w_phase;
    logic [RAM_SIZE-1:0] w_p_inc;
    logic [RAM_SIZE-1:0] w_load_addr;

    // A beat in IDLE is the first X of a new vector: treat it as pair 0, phase X.
    assign w_accept    = i_in_valid & r_in_ready;
    assign w_first     = (r_state == S_IDLE);
    assign w_p         = w_first ? '0 : r_p;
    assign w_phase     = w_first ? 1'b0 : r_phase;
    assign w_p_inc     = w_p + L_ONE;
    assign w_load_addr = {w_p[RAM_SIZE-2:0], w_phase};

    // Load writes go straight to the RAM in the cycle the beat is accepted.
    always_comb begin
        o_wenable = w_accept;
        o_wdata   = w_accept ? i_in_data : '0;
        o_addr    = w_accept ? w_load_addr : r_addr;
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_out_last     = r_out_last;
    assign o_ndata        = r_ndata;
    assign o_startvd      = r_startvd;
    assign o_ram_owner_vd = r_owner;
    assign o_err          = r_err;

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_p         <= '0;
            r_phase     <= 1'b0;
            r_r         <= '0;
            r_addr      <= '0;
            r_ndata     <= '0;
            r_startvd   <= 1'b0;
            r_owner     <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_startvd <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_err <= 1'b0;
                        end
                        if (!w_phase) begin
                            if (i_in_last) begin
                                // orphan X: written, but it has no partner
                                r_err   <= 1'b1;
                                r_ndata <= w_p;
                                if (w_p != '0) begin
                                    r_state    <= S_START;
                                    r_in_ready <= 1'b0;
                                    r_startvd  <= 1'b1;
                                    r_owner    <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_p     <= w_p;
                                r_phase <= 1'b1;
                                r_state <= S_LOAD;
                            end
                        end else begin
                            if (i_in_last) begin
                                r_ndata    <= w_p_inc;
                                r_state    <= S_START;
                                r_in_ready <= 1'b0;
                                r_startvd  <= 1'b1;
                                r_owner    <= 1'b1;
                            end else if (w_p_inc == L_MAX) begin
                                // capacity reached without in_last
                                r_err      <= 1'b1;
                                r_ndata    <= L_MAX;
                                r_state    <= S_START;
                                r_in_ready <= 1'b0;
                                r_startvd  <= 1'b1;
                                r_owner    <= 1'b1;
                            end else begin
                                r_p     <= w_p_inc;
                                r_phase <= 1'b0;
                            end
                        end
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i_busyvd) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!i_busyvd) begin
                        r_owner <= 1'b0;
                        r_r     <= '0;
                        r_addr  <= L_RES_BASE;
                        r_state <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    r_addr  <= '0;
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    r_out_data  <= i_rdata;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_r == (r_ndata - L_ONE));
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_r     <= r_r + L_ONE;
                            r_addr  <= L_RES_BASE + r_r + L_ONE;
                            r_state <= S_RD_ADDR;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_owner    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vd_host.sv
// Bench for vd_host: shared RAM model with owner mux, behavioural divider,
// scoreboard queue of expected quotients checked by an independent monitor.
module tb_vd_host;

    localparam int RS = 10;
    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_in_valid = 1'b0;
    logic          o_in_ready;
    logic [NB-1:0] i_in_data = '0;
    logic          i_in_last = 1'b0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b1;
    logic [NB-1:0] o_out_data;
    logic          o_out_last;
    logic [RS-1:0] o_addr;
    logic [NB-1:0] o_wdata;
    logic          o_wenable;
    logic [NB-1:0] i_rdata = '0;
    logic [RS-1:0] o_ndata;
    logic          o_startvd;
    logic          i_busyvd = 1'b0;
    logic          o_ram_owner_vd;
    logic          o_err;

    vd_host #(.RAM_SIZE(RS), .NBITS(NB), .RES_BASE(512), .MAX_PAIRS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_in_last(i_in_last),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_data(o_out_data), .o_out_last(o_out_last),
        .o_addr(o_addr), .o_wdata(o_wdata), .o_wenable(o_wenable),
        .i_rdata(i_rdata), .o_ndata(o_ndata), .o_startvd(o_startvd),
        .i_busyvd(i_busyvd), .o_ram_owner_vd(o_ram_owner_vd), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [NB-1:0] d; logic l; } exp_t;
    exp_t exp_q[$];
    logic [NB-1:0] vec[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // ---------------- RAM model (single process owns the array) -----------
    logic [NB-1:0] ram [1024];
    logic          dv_we = 1'b0;
    logic [RS-1:0] dv_addr = '0;
    logic [NB-1:0] dv_wdata = '0;
    int host_writes = 0;
    int host_reads  = 0;

    always @(posedge clk) begin
        if (o_ram_owner_vd) begin
            if (dv_we) ram[dv_addr] = dv_wdata;
        end else begin
            i_rdata <= ram[o_addr];
            if (o_wenable) begin
                ram[o_addr] = o_wdata;
                host_writes++;
            end else if (o_addr >= 10'd512) begin
                host_reads++;
            end
        end
    end

    // ---------------- divider model ----------------------------------------
    int rise_delay = 0;
    int starts = 0;
    int own_faults = 0;
    int addr_faults = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (o_startvd === 1'b1) begin
                int nd;
                starts++;
                nd = int'(o_ndata);
                if (o_ram_owner_vd !== 1'b1) own_faults++;
                @(posedge clk); #1;
                repeat (rise_delay) begin
                    @(negedge clk);
                    if (o_ram_owner_vd !== 1'b1) own_faults++;
                    if (o_addr !== '0) addr_faults++;
                    @(posedge clk); #1;
                end
                i_busyvd = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    dv_we    = (k < nd);
                    dv_addr  = RS'(512 + k);
                    dv_wdata = (k < nd) ? ram[2*k] / ram[2*k+1] : '0;
                    @(negedge clk);
                    if (o_ram_owner_vd !== 1'b1) own_faults++;
                    if (o_addr !== '0) addr_faults++;
                    @(posedge clk); #1;
                end
                dv_we    = 1'b0;
                i_busyvd = 1'b0;
            end
        end
    end

    // ---------------- out_ready driver --------------------------------------
    int rmode = 0;   // 0 always ready, 1 ready one cycle in three, 2 never
    int rcyc  = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            rcyc++;
            case (rmode)
                0: i_out_ready = 1'b1;
                1: i_out_ready = ((rcyc % 3) == 0);
                default: i_out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor -----------------------------------------------
    int stall_faults = 0;
    logic stall_prev = 1'b0;
    logic [NB-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(negedge clk) begin
        if (o_out_valid && stall_prev) begin
            if (o_out_data !== prev_data || o_out_last !== prev_last) stall_faults++;
        end
        if (o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0d want none", o_out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result: data=%0d last=%0d (want %0d/%0d)", o_out_data, o_out_last, e.d, e.l);
                chk("out_data", o_out_data, e.d);
                chk("out_last", 32'(o_out_last), 32'(e.l));
            end
        end
        stall_prev = o_out_valid && !i_out_ready;
        prev_data  = o_out_data;
        prev_last  = o_out_last;
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic send_vec(input int base, input bit last_final, output int acc);
        acc = 0;
        for (int i = 0; i < vec.size(); i++) begin
            @(posedge clk); #1;
            i_in_valid = 1'b1;
            i_in_data  = vec[i];
            i_in_last  = last_final && (i == vec.size() - 1);
            @(negedge clk);
            if (o_in_ready) begin
                acc++;
                $display("load beat: addr=%0d data=%0d last=%0d", o_addr, o_wdata, i_in_last);
                chk("wenable", 32'(o_wenable), 1);
                chk("waddr", 32'(o_addr), base + i);
                chk("wdata", o_wdata, vec[i]);
            end else begin
                $display("load beat refused: data=%0d", vec[i]);
                chk("wenable_refused", 32'(o_wenable), 0);
            end
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        i_in_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && o_in_ready && !o_out_valid && !o_ram_owner_vd) done = 1;
        end
        chk({name, "_done"}, 32'(done), 1);
    endtask

    task automatic basic_vec();
        vec = '{32'd100, 32'd5, 32'd81, 32'd9, 32'd7, 32'd2};
        exp_q.push_back('{d: 32'd20, l: 1'b0});
        exp_q.push_back('{d: 32'd9,  l: 1'b0});
        exp_q.push_back('{d: 32'd3,  l: 1'b1});
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        int acc, s0, r0, w0, of0, af0, sf0;

        // reset state
        #23;
        chk("rst_in_ready", 32'(o_in_ready), 1);
        chk("rst_out_valid", 32'(o_out_valid), 0);
        chk("rst_out_last", 32'(o_out_last), 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_wenable", 32'(o_wenable), 0);
        chk("rst_ndata", 32'(o_ndata), 0);
        chk("rst_startvd", 32'(o_startvd), 0);
        chk("rst_owner", 32'(o_ram_owner_vd), 0);
        chk("rst_err", 32'(o_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic run
        s0 = starts; r0 = host_reads; of0 = own_faults;
        basic_vec();
        send_vec(0, 1, acc);
        chk("basic_ndata", 32'(o_ndata), 3);
        wait_idle("basic");
        chk("basic_ram0", ram[0], 100);
        chk("basic_ram3", ram[3], 9);
        chk("basic_ram5", ram[5], 2);
        chk("basic_starts", starts - s0, 1);
        chk("basic_reads", host_reads - r0, 3);
        chk("basic_err", 32'(o_err), 0);
        chk("basic_owner_faults", own_faults - of0, 0);

        // backpressure
        rmode = 1;
        s0 = starts; r0 = host_reads; sf0 = stall_faults;
        basic_vec();
        send_vec(0, 1, acc);
        wait_idle("bp");
        chk("bp_starts", starts - s0, 1);
        chk("bp_reads", host_reads - r0, 3);
        chk("bp_stall_faults", stall_faults - sf0, 0);
        rmode = 0;

        // single orphan X: no run
        s0 = starts;
        vec = '{32'd77};
        send_vec(0, 1, acc);
        repeat (4) @(negedge clk);
        chk("single_err", 32'(o_err), 1);
        chk("single_ndata", 32'(o_ndata), 0);
        chk("single_idle", 32'(o_in_ready), 1);
        chk("single_starts", starts - s0, 0);
        chk("single_ram0", ram[0], 77);

        // orphan X after one pair
        s0 = starts;
        vec = '{32'd10};
        send_vec(0, 0, acc);
        @(negedge clk);
        chk("orphan_err_cleared", 32'(o_err), 0);
        vec = '{32'd2, 32'd30};
        exp_q.push_back('{d: 32'd5, l: 1'b1});
        send_vec(1, 1, acc);
        chk("orphan_err", 32'(o_err), 1);
        chk("orphan_ndata", 32'(o_ndata), 1);
        wait_idle("orphan");
        chk("orphan_ram2", ram[2], 30);
        chk("orphan_starts", starts - s0, 1);

        // delayed busy rise
        rise_delay = 5;
        s0 = starts; r0 = host_reads; of0 = own_faults; af0 = addr_faults;
        basic_vec();
        send_vec(0, 1, acc);
        wait_idle("delay");
        chk("delay_starts", starts - s0, 1);
        chk("delay_reads", host_reads - r0, 3);
        chk("delay_owner_faults", own_faults - of0, 0);
        chk("delay_addr_faults", addr_faults - af0, 0);
        rise_delay = 0;

        // overflow at MAX_PAIRS=4
        s0 = starts; w0 = host_writes;
        vec = '{32'd40, 32'd4, 32'd90, 32'd3, 32'd8, 32'd8, 32'd100, 32'd7, 32'd5, 32'd5};
        exp_q.push_back('{d: 32'd10, l: 1'b0});
        exp_q.push_back('{d: 32'd30, l: 1'b0});
        exp_q.push_back('{d: 32'd1,  l: 1'b0});
        exp_q.push_back('{d: 32'd14, l: 1'b1});
        send_vec(0, 0, acc);
        chk("ovf_accepted", acc, 8);
        chk("ovf_writes", host_writes - w0, 8);
        chk("ovf_in_ready", 32'(o_in_ready), 0);
        chk("ovf_err", 32'(o_err), 1);
        chk("ovf_ndata", 32'(o_ndata), 4);
        wait_idle("ovf");
        chk("ovf_starts", starts - s0, 1);

        // asynchronous reset while presenting a result
        rmode = 2;
        vec = '{32'd100, 32'd5, 32'd81, 32'd9, 32'd7, 32'd2};
        send_vec(0, 1, acc);
        begin
            bit seen = 0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                if (o_out_valid) seen = 1;
            end
            chk("arst_reached_out", 32'(seen), 1);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(o_out_valid), 0);
        chk("arst_owner", 32'(o_ram_owner_vd), 0);
        chk("arst_ndata", 32'(o_ndata), 0);
        chk("arst_in_ready", 32'(o_in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        rmode = 0;

        // fresh run after reset
        s0 = starts;
        basic_vec();
        send_vec(0, 1, acc);
        wait_idle("post_rst");
        chk("post_rst_starts", starts - s0, 1);
        chk("post_rst_err", 32'(o_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vd_host.md
# vd_host

Host-side initiator for the vector divider. It accepts a stream of (X, Y) operand pairs, writes them into the shared 1024x32 RAM, and programs Ndata. It then starts the divider with a startvd pulse, waits for the busyvd cycle to complete, and streams the quotients back out of RAM. It owns the RAM port whenever the divider is idle and grants the port to the divider for the run phase.

## Interface
- RAM_SIZE, 10: RAM address width.
- NBITS, 32: data width.
- RES_BASE, 512: RAM address where the divider writes quotient i (RES_BASE+i).
- MAX_PAIRS, 256: pair capacity; must satisfy 2*MAX_PAIRS <= RES_BASE.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1  operand stream handshake; a beat transfers when both are high.
- in_data  in  NBITS  operand word; words alternate X, Y, X, Y…
- in_last  in  1  marks the final word of the vector.
- out_valid / out_ready  out / in  1  result stream handshake.
- out_data  out  NBITS  quotient word.
- out_last  out  1  marks the final quotient.
- Addr  out  RAM_SIZE  RAM address (host side of the RAM mux).
- Wdata  out  NBITS  RAM write data.
- Wenable  out  1  RAM write strobe.
- Rdata  in  NBITS  RAM read data; synchronous read, valid the cycle after Addr.
- Ndata  out  RAM_SIZE  pair count presented to the divider.
- startvd  out  1  one-cycle start pulse to the divider.
- busyvd  in  1  divider busy.
- ram_owner_vd  out  1  1 = RAM mux selects the divider's Addr/Wdata/Wenable.
- err  out  1  sticky error flag; cleared on the next accepted first X.

## Operation
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO, RD_ADDR, RD_DATA, OUT.
- **IDLE:**
  - in_ready=1.
  - The first accepted beat goes to LOAD processing: it clears the pair counter p, sets phase=X and clears err.
- **LOAD:**
  - in_ready=1.
  - Each accepted beat writes RAM in the same cycle: Wenable=1, Wdata=in_data, Addr=2*p+phase (X=0, Y=1).
  - After a Y beat, p increments.
- **Load termination:**
  - in_last on a Y beat: Ndata<=p+1, go to START.
  - in_last on an X beat: the orphan X is written, err<=1, Ndata<=p; go to START if p>0, else IDLE.
  - p reaching MAX_PAIRS without in_last: err<=1, Ndata<=MAX_PAIRS, go to START; no further beats are accepted.
- **START:**
  - startvd=1 for exactly one cycle; ram_owner_vd=1.
  - Go to WAIT_HI.
- **WAIT_HI:** ram_owner_vd=1; leave to WAIT_LO when busyvd=1.
- **WAIT_LO:** ram_owner_vd=1; leave to RD_ADDR when busyvd=0, with result index r=0.
- **RD_ADDR:** ram_owner_vd=0, Addr=RES_BASE+r, go to RD_DATA.
- **RD_DATA:** capture Rdata into out_data, go to OUT.
- **OUT:**
  - out_valid=1; out_last=(r==Ndata-1).
  - On out_ready: if last, go to IDLE; else r++ and go to RD_ADDR.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- **Widths:** p and r are RAM_SIZE bits; address arithmetic is modulo 2^RAM_SIZE (no wrap under legal parameters).
- **Outputs outside the states above:**
  - in_ready=0 outside IDLE/LOAD.
  - Wenable=0 outside accepted load beats.
  - Addr/Wdata=0 when not in use.
- **Ndata:** holds its value from load end until the next load ends.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, out_last=0, out_data=0, Addr=0, Wdata=0, Wenable=0, Ndata=0, startvd=0, ram_owner_vd=0, err=0.
- **Reset mid-operation:** immediate return to IDLE with the above values. RAM contents are untouched; the divider is not signalled.
- **Load rate:** one word per cycle, zero-latency write.
- **Start:** startvd occurs in the cycle after the final load beat.
- **Wait:** ram_owner_vd rises with startvd and falls in the cycle after busyvd is sampled low in WAIT_LO.
- **Readout:**
  - First out_valid comes 3 cycles after busyvd is sampled low.
  - Maximum rate is one result per 3 cycles (RD_ADDR, RD_DATA, OUT).
- busyvd already high when entering WAIT_HI is accepted next cycle. There is no timeout; a divider that never raises busyvd holds the block in WAIT_HI until reset.
- in_valid during START..OUT is ignored (in_ready=0).

## Test plan
- **Basic run:** load X/Y pairs (100,5), (81,9), (7,2) with in_last on the final Y.
  - RAM[0..5]=100,5,81,9,7,2; Ndata=3; one startvd pulse.
  - Model divider busy 10 cycles, writes RAM[512..514]=20,9,3.
  - Required: out stream 20,9,3 with out_last on 3; err=0.
- **Backpressure:** same run with out_ready toggling 1-of-3 cycles → identical stream; out_data stable while stalled; no extra RAM reads observed.
- **Orphan X:** beats 10,2,30 with in_last on 30 → RAM[2]=30 written, err=1, Ndata=1, run proceeds, single result returned. Separately, a single X beat with in_last → err=1, back to IDLE, no startvd.
- **Overflow:** MAX_PAIRS=4, stream 10 words without in_last → 8 writes, in_ready drops after the 8th, err=1, Ndata=4, startvd issued.
- **Handshake ordering:** delay busyvd rise by 5 cycles → ram_owner_vd stays 1 throughout; no RAM read before busyvd falls.
- **Async reset:** assert reset during OUT with out_valid=1 → out_valid, ram_owner_vd and Ndata go to 0 without a clock edge; a fresh load after release runs correctly.
